// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state type for the SPI byte front-end
package spi_pkg;

    localparam int SPI_WORD_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fsm_t;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-flop input synchroniser with configurable reset value
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {N{RST_VAL}};
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/spi_byte_frontend.sv
// rtl/spi_byte_frontend.sv - oversampled SPI mode-0 slave: byte deserialiser and serialiser
module spi_byte_frontend
    import spi_pkg::*;
#(
    parameter int WORD_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_active,
    output logic              frame_abort,
    output logic              tx_underrun
);

    localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs_n), .q(cs_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    fsm_t             state, state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] rx_shift, tx_shift, rx_next;
    logic              enter, load, shift_rx, shift_tx, word_done, abort;

    assign rx_next = {rx_shift[WORD_W-2:0], mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // cs_n edges take priority: any sclk edge seen in the same cycle is dropped
    always_comb begin
        state_d   = state;
        enter     = 1'b0;
        load      = 1'b0;
        shift_rx  = 1'b0;
        shift_tx  = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    enter   = 1'b1;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort   = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    shift_rx  = 1'b1;
                    word_done = (bit_cnt == CNT_LAST);
                end else if (sclk_fall) begin
                    if (bit_cnt == '0) begin
                        load = 1'b1;
                    end else begin
                        shift_tx = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= word_done;
            frame_abort <= abort;
            if (enter) begin
                bit_cnt <= '0;
            end
            if (shift_rx) begin
                rx_shift <= rx_next;
                bit_cnt  <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
                if (word_done) begin
                    rx_data <= rx_next;
                end
            end
            if (load) begin
                tx_shift <= tx_valid ? tx_data : '0;
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
            end
        end
    end

    assign tx_ready     = load & tx_valid;
    assign tx_underrun  = load & ~tx_valid;
    assign frame_active = (state == ACTIVE);
    assign miso         = frame_active & tx_shift[WORD_W-1];

endmodule
